// File: rtl/delay_line_store.sv
// delay_line_store: time-multiplexed serial recirculating bit store.
//
// NCH channels of DEPTH bits each share one line of L = NCH*DEPTH single-bit
// cells. Every BIT_EN edge processes cell A = BITPOS*NCH + CH: the old bit
// emerges on DLO and is written back as either 0 (CLR), DIN (WR_EN) or itself.
// A bit therefore re-emerges exactly L advances after it was written.
//
// Ports:
//   SIM_CLK  in   clock, rising edge
//   SIM_RST  in   asynchronous active-low reset, clears everything
//   BIT_EN   in   advance the line one cell
//   SYNC     in   force CH/BITPOS to 0 without shifting (overrides BIT_EN)
//   CLR      in   write back 0 (priority over WR_EN)
//   WR_EN    in   write back DIN instead of recirculating
//   DIN      in   serial write data
//   DLO      out  registered bit that emerged on the last advance
//   CH       out  channel slot of the next cell
//   BITPOS   out  bit position of the next cell
//   WRAP     out  one-cycle pulse after the last cell of the line was processed
//   CR       out  per-channel latch of that channel's latest emerging bit
//   CRD      out  per-channel previous CR value

`timescale 1ns/1ps

module delay_line_store #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned DEPTH = 28,
    localparam int unsigned L    = NCH * DEPTH,
    localparam int unsigned CW   = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int unsigned BW   = $clog2(DEPTH),
    localparam int unsigned AW   = $clog2(L)
) (
    input  logic            SIM_CLK,
    input  logic            SIM_RST,
    input  logic            BIT_EN,
    input  logic            SYNC,
    input  logic            CLR,
    input  logic            WR_EN,
    input  logic            DIN,
    output logic            DLO,
    output logic [CW-1:0]   CH,
    output logic [BW-1:0]   BITPOS,
    output logic            WRAP,
    output logic [NCH-1:0]  CR,
    output logic [NCH-1:0]  CRD
);

    logic [L-1:0]   cells_q, cells_d;
    logic [CW-1:0]  ch_q, ch_d;
    logic [BW-1:0]  bitpos_q, bitpos_d;
    logic           dlo_q, dlo_d;
    logic           wrap_q, wrap_d;
    logic [NCH-1:0] cr_q, cr_d;
    logic [NCH-1:0] crd_q, crd_d;

    logic [AW-1:0]  addr;
    logic           cur_bit;
    logic           src_bit;
    logic           last_ch;
    logic           last_bit;

    always_comb begin
        addr     = AW'(bitpos_q) * AW'(NCH) + AW'(ch_q);
        cur_bit  = cells_q[addr];
        src_bit  = CLR ? 1'b0 : (WR_EN ? DIN : cur_bit);
        last_ch  = (ch_q == CW'(NCH - 1));
        last_bit = (bitpos_q == BW'(DEPTH - 1));

        cells_d  = cells_q;
        ch_d     = ch_q;
        bitpos_d = bitpos_q;
        dlo_d    = dlo_q;
        cr_d     = cr_q;
        crd_d    = crd_q;
        wrap_d   = 1'b0;

        if (SYNC) begin
            ch_d     = '0;
            bitpos_d = '0;
        end else if (BIT_EN) begin
            dlo_d         = cur_bit;
            cells_d[addr] = src_bit;
            // CR captures the emerging (old) bit, not the value written back.
            crd_d[ch_q]   = cr_q[ch_q];
            cr_d[ch_q]    = cur_bit;
            if (last_ch) begin
                ch_d = '0;
                if (last_bit) begin
                    bitpos_d = '0;
                    wrap_d   = 1'b1;
                end else begin
                    bitpos_d = bitpos_q + 1'b1;
                end
            end else begin
                ch_d = ch_q + 1'b1;
            end
        end
    end

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            cells_q  <= '0;
            ch_q     <= '0;
            bitpos_q <= '0;
            dlo_q    <= 1'b0;
            wrap_q   <= 1'b0;
            cr_q     <= '0;
            crd_q    <= '0;
        end else begin
            cells_q  <= cells_d;
            ch_q     <= ch_d;
            bitpos_q <= bitpos_d;
            dlo_q    <= dlo_d;
            wrap_q   <= wrap_d;
            cr_q     <= cr_d;
            crd_q    <= crd_d;
        end
    end

    assign DLO    = dlo_q;
    assign CH     = ch_q;
    assign BITPOS = bitpos_q;
    assign WRAP   = wrap_q;
    assign CR     = cr_q;
    assign CRD    = crd_q;

endmodule
